// File: rtl/staggered_sub.sv
// staggered_sub: four-stage pipelined subtractor, D = A - B - Bin.
// The LSB half is subtracted in EX1. The MSB half is subtracted in EX2,
// using the LSB borrow registered between the two stages, so the carry chain
// never spans a full word in one cycle. Valid tracking, a global hold and
// compare flags are registered in WB.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (wins over hold)
//   hold       freezes every pipeline register, outputs included
//   valid_in   A/B/Bin carry a real operation this cycle
//   A, B, Bin  minuend, subtrahend, borrow-in
//   D          difference modulo 2^width
//   Bout       borrow-out (A < B + Bin, unsigned)
//   V          two's-complement overflow of A - B - Bin
//   Z          D == 0
//   valid_out  D/Bout/V/Z hold a real result
module staggered_sub #(
  parameter int unsigned width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             valid_in,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             Bin,
  output logic [width-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             Z,
  output logic             valid_out
);

  localparam int unsigned half = width / 2;

  // DF stage
  logic [half-1:0]  df_a_lo_q, df_a_hi_q, df_b_lo_q, df_b_hi_q;
  logic             df_bin_q, df_vld_q;

  // EX1 stage
  logic [half-1:0]  ex1_dl_q, ex1_a_hi_q, ex1_b_hi_q;
  logic             ex1_bl_q, ex1_vld_q, ex1_as_q, ex1_bs_q;

  // EX2 stage
  logic [width-1:0] ex2_diff_q;
  logic             ex2_bm_q, ex2_vld_q, ex2_as_q, ex2_bs_q;

  // WB stage
  logic [width-1:0] wb_d_q;
  logic             wb_bout_q, wb_v_q, wb_z_q, wb_vld_q;

  // Half-width subtractions; the extra top bit is the borrow-out.
  logic [half:0]    ex1_sub_d, ex2_sub_d;
  logic             wb_v_d, wb_z_d;

  always_comb begin
    ex1_sub_d = {1'b0, df_a_lo_q} - {1'b0, df_b_lo_q} - {{half{1'b0}}, df_bin_q};
    ex2_sub_d = {1'b0, ex1_a_hi_q} - {1'b0, ex1_b_hi_q} - {{half{1'b0}}, ex1_bl_q};
    // Overflow only possible when operand signs differ; Bin is already
    // folded into the full difference.
    wb_v_d    = (ex2_as_q != ex2_bs_q) && (ex2_diff_q[width-1] != ex2_as_q);
    wb_z_d    = (ex2_diff_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      df_a_lo_q  <= '0;
      df_a_hi_q  <= '0;
      df_b_lo_q  <= '0;
      df_b_hi_q  <= '0;
      df_bin_q   <= 1'b0;
      df_vld_q   <= 1'b0;
      ex1_dl_q   <= '0;
      ex1_a_hi_q <= '0;
      ex1_b_hi_q <= '0;
      ex1_bl_q   <= 1'b0;
      ex1_vld_q  <= 1'b0;
      ex1_as_q   <= 1'b0;
      ex1_bs_q   <= 1'b0;
      ex2_diff_q <= '0;
      ex2_bm_q   <= 1'b0;
      ex2_vld_q  <= 1'b0;
      ex2_as_q   <= 1'b0;
      ex2_bs_q   <= 1'b0;
      wb_d_q     <= '0;
      wb_bout_q  <= 1'b0;
      wb_v_q     <= 1'b0;
      wb_z_q     <= 1'b0;
      wb_vld_q   <= 1'b0;
    end else if (!hold) begin
      // DF
      df_a_lo_q  <= A[half-1:0];
      df_a_hi_q  <= A[width-1:half];
      df_b_lo_q  <= B[half-1:0];
      df_b_hi_q  <= B[width-1:half];
      df_bin_q   <= Bin;
      df_vld_q   <= valid_in;
      // EX1
      ex1_dl_q   <= ex1_sub_d[half-1:0];
      ex1_bl_q   <= ex1_sub_d[half];
      ex1_a_hi_q <= df_a_hi_q;
      ex1_b_hi_q <= df_b_hi_q;
      ex1_as_q   <= df_a_hi_q[half-1];
      ex1_bs_q   <= df_b_hi_q[half-1];
      ex1_vld_q  <= df_vld_q;
      // EX2
      ex2_diff_q <= {ex2_sub_d[half-1:0], ex1_dl_q};
      ex2_bm_q   <= ex2_sub_d[half];
      ex2_as_q   <= ex1_as_q;
      ex2_bs_q   <= ex1_bs_q;
      ex2_vld_q  <= ex1_vld_q;
      // WB
      wb_d_q     <= ex2_diff_q;
      wb_bout_q  <= ex2_bm_q;
      wb_v_q     <= wb_v_d;
      wb_z_q     <= wb_z_d;
      wb_vld_q   <= ex2_vld_q;
    end
  end

  assign D         = wb_d_q;
  assign Bout      = wb_bout_q;
  assign V         = wb_v_q;
  assign Z         = wb_z_q;
  assign valid_out = wb_vld_q;

endmodule

// File: tb/tb_staggered_sub.sv
// tb_staggered_sub: directed self-checking bench for staggered_sub.
// Inputs change 1 time unit after a rising edge; outputs are captured on the
// falling edge. Every valid result is logged with the edge count at which it
// appeared and compared against hand-computed expectations.
module tb_staggered_sub;

  logic        clk = 1'b0;
  logic        reset, hold, valid_in, Bin;
  logic [15:0] A, B;
  logic [15:0] D;
  logic        Bout, V, Z, valid_out;

  staggered_sub #(.width(16)) dut (
    .clk(clk), .reset(reset), .hold(hold), .valid_in(valid_in),
    .A(A), .B(B), .Bin(Bin),
    .D(D), .Bout(Bout), .V(V), .Z(Z), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int unsigned cyc;
    logic [15:0] d;
    logic        b, v, z;
  } res_t;

  res_t got[$];
  res_t exp_q[$];

  always @(negedge clk) begin
    if (valid_out === 1'b1) got.push_back('{cyc, D, Bout, V, Z});
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic bi, input logic vld);
    A = a; B = b; Bin = bi; valid_in = vld;
  endtask

  task automatic idle(input int n);
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) step();
  endtask

  // Expected result appearing after edge number c.
  task automatic expect_op(input int unsigned c, input logic [15:0] d, input logic b,
                           input logic v, input logic z);
    exp_q.push_back('{c, d, b, v, z});
  endtask

  task automatic check_results(input string tag);
    int n;
    chk({tag, ".count"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d].cyc", tag, i), got[i].cyc, exp_q[i].cyc);
      chk($sformatf("%s[%0d].D",   tag, i), got[i].d,   exp_q[i].d);
      chk($sformatf("%s[%0d].Bout",tag, i), got[i].b,   exp_q[i].b);
      chk($sformatf("%s[%0d].V",   tag, i), got[i].v,   exp_q[i].v);
      chk($sformatf("%s[%0d].Z",   tag, i), got[i].z,   exp_q[i].z);
    end
    got.delete();
    exp_q.delete();
  endtask

  int unsigned p;
  logic [15:0] sa [6];
  logic [15:0] sd [6];
  logic        sbin [6];

  initial begin
    // k*0x1111 - 0x0101 - k[0]
    sa   = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    sbin = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    sd   = '{16'h100F, 16'h2121, 16'h3231, 16'h4343, 16'h5453, 16'h6565};

    reset = 1'b1; hold = 1'b0;
    drive(16'hFFFF, 16'h1234, 1'b1, 1'b1);
    step(); step(); step();
    chk("rst.valid_out", valid_out, 1'b0);
    chk("rst.D", D, 16'h0000);
    chk("rst.Bout", Bout, 1'b0);
    chk("rst.V", V, 1'b0);
    chk("rst.Z", Z, 1'b0);
    reset = 1'b0;
    idle(6);
    got.delete();

    // T1: single op, 4-cycle latency, single-cycle valid_out
    p = cyc;
    drive(16'h1234, 16'h0234, 1'b0, 1'b1); step();
    expect_op(p + 4, 16'h1000, 1'b0, 1'b0, 1'b0);
    idle(8);
    check_results("t1");

    // T2: LSB borrow crossing halves, then zero result
    p = cyc;
    drive(16'h0100, 16'h0001, 1'b0, 1'b1); step();
    drive(16'h0005, 16'h0005, 1'b0, 1'b1); step();
    expect_op(p + 4, 16'h00FF, 1'b0, 1'b0, 1'b0);
    expect_op(p + 5, 16'h0000, 1'b0, 1'b0, 1'b1);
    idle(8);
    check_results("t2");

    // T3: wrap-around and signed overflow
    p = cyc;
    drive(16'h0000, 16'h0000, 1'b1, 1'b1); step();
    drive(16'h8000, 16'h0001, 1'b0, 1'b1); step();
    drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b1); step();
    expect_op(p + 4, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    expect_op(p + 5, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    expect_op(p + 6, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    idle(8);
    check_results("t3");

    // T4: six back-to-back ops
    p = cyc;
    for (int k = 0; k < 6; k++) begin
      drive(sa[k], 16'h0101, sbin[k], 1'b1); step();
      expect_op(p + 4 + k, sd[k], 1'b0, 1'b0, 1'b0);
    end
    idle(10);
    check_results("t4");

    // T5: same stream, hold for 2 cycles after the third op enters
    p = cyc;
    for (int k = 0; k < 3; k++) begin
      drive(sa[k], 16'h0101, sbin[k], 1'b1); step();
    end
    drive(sa[3], 16'h0101, sbin[3], 1'b1);
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      // WB still holds the idle bubble (zero data) while frozen
      chk($sformatf("t5.hold%0d.valid_out", i), valid_out, 1'b0);
      chk($sformatf("t5.hold%0d.D", i), D, 16'h0000);
    end
    hold = 1'b0;
    for (int k = 3; k < 6; k++) begin
      drive(sa[k], 16'h0101, sbin[k], 1'b1); step();
    end
    for (int k = 0; k < 6; k++) expect_op(p + 6 + k, sd[k], 1'b0, 1'b0, 1'b0);
    idle(12);
    check_results("t5");

    // T6: reset (with hold) flushes three in-flight ops
    for (int k = 0; k < 3; k++) begin
      drive(sa[k], 16'h0101, sbin[k], 1'b1); step();
    end
    drive(sa[3], 16'h0101, sbin[3], 1'b1);
    reset = 1'b1; hold = 1'b1;
    step();
    chk("t6.rst.valid_out", valid_out, 1'b0);
    chk("t6.rst.D", D, 16'h0000);
    chk("t6.rst.Bout", Bout, 1'b0);
    chk("t6.rst.V", V, 1'b0);
    chk("t6.rst.Z", Z, 1'b0);
    reset = 1'b0; hold = 1'b0;
    p = cyc;
    drive(16'hA5A5, 16'h5A5A, 1'b0, 1'b1); step();
    expect_op(p + 4, 16'h4B4B, 1'b0, 1'b1, 1'b0);
    idle(10);
    check_results("t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
